// File: rtl/y_mux_defs.sv
// y_mux_defs: shared constants and helpers for the y_rr_mux slice.
//   MODE_RR    - mode input value selecting round-robin arbitration
//   MODE_FIXED - mode input value selecting fixed priority (lowest index wins)
//   clog2()    - ceiling log2, used to derive the channel-index width CW
package y_mux_defs;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/y_rr_arbiter.sv
// y_rr_arbiter: purely combinational winner selection for y_rr_mux.
// Ports:
//   in_valid  [CHANNELS] per-channel request
//   ptr       [CW]       highest-priority channel in round-robin mode
//   mode      1          MODE_RR or MODE_FIXED
//   winner    [CW]       selected channel (0 when nothing requests)
//   any_valid 1          at least one channel requests
module y_rr_arbiter
  import y_mux_defs::*;
#(
  parameter  int CHANNELS = 4,
  localparam int CW       = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [CW-1:0]       ptr,
  input  logic                mode,
  output logic [CW-1:0]       winner,
  output logic                any_valid
);

  logic          found;
  logic [CW:0]   sum;
  logic [CW-1:0] idx;

  always_comb begin
    winner    = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    any_valid = |in_valid;
    if (mode == MODE_FIXED) begin
      // Scan downwards so the lowest requesting index is the last write.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) winner = CW'(i);
      end
    end else begin
      // Visit ptr, ptr+1, ... with a single conditional subtract for the
      // wrap; ptr < CHANNELS, so ptr+k never reaches 2*CHANNELS.
      for (int k = 0; k < CHANNELS; k++) begin
        sum = {1'b0, ptr} + (CW+1)'(k);
        if (sum >= (CW+1)'(CHANNELS)) sum = sum - (CW+1)'(CHANNELS);
        idx = sum[CW-1:0];
        if (!found && in_valid[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/y_rr_mux.sv
// y_rr_mux: N-channel registered multiplexer with built-in arbitration.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   mode        0 = round-robin, 1 = fixed priority
//   in_valid    [CHANNELS]      per-channel request
//   in_data     [CHANNELS*SIZE] channel i at [i*SIZE +: SIZE]
//   in_ready    [CHANNELS]      one-hot or zero: that channel's word is taken
//   out_valid   1               output register holds a word
//   out_ready   1               consumer accepts this cycle
//   out_data    [SIZE]          registered winning word
//   out_chan    [CW]            registered index of the winning channel
//
// Handshake: a word moves across an interface on a rising edge where both its
// valid and ready are high. in_ready depends combinationally on in_valid, so
// producers must not wait for in_ready before raising in_valid. out_valid
// never depends on out_ready, and out_data/out_chan are stable while
// out_valid=1 and out_ready=0.
module y_rr_mux
  import y_mux_defs::*;
#(
  parameter  int SIZE     = 32,
  parameter  int CHANNELS = 4,
  localparam int CW       = clog2(CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [CHANNELS-1:0]      in_valid,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  output logic [CHANNELS-1:0]      in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE-1:0]          out_data,
  output logic [CW-1:0]            out_chan
);

  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  logic [CW-1:0] ptr;
  logic [CW-1:0] winner;
  logic          any_valid;
  logic          space;
  logic          load;
  logic [SIZE-1:0] sel_data;

  y_rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .in_valid  (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // The register has room when empty or when its word leaves this edge.
  // Gating with reset voids any acknowledge in a reset cycle.
  assign space    = ~out_valid | out_ready;
  assign load     = any_valid & space & ~reset;
  assign sel_data = in_data[int'(winner)*SIZE +: SIZE];

  always_comb begin
    in_ready = '0;
    if (load) in_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= winner;
      if (mode == MODE_RR) ptr <= (winner == LAST) ? '0 : winner + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_y_rr_mux.sv
module tb_y_rr_mux;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-channel, 32-bit instance
  logic         mode;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_chan;

  // 3-channel, 8-bit instance
  logic         c3_mode;
  logic [2:0]   c3_in_valid;
  logic [23:0]  c3_in_data;
  logic [2:0]   c3_in_ready;
  logic         c3_out_valid;
  logic         c3_out_ready;
  logic [7:0]   c3_out_data;
  logic [1:0]   c3_out_chan;

  y_rr_mux #(.SIZE(32), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan)
  );

  y_rr_mux #(.SIZE(8), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .mode(c3_mode),
    .in_valid(c3_in_valid), .in_data(c3_in_data), .in_ready(c3_in_ready),
    .out_valid(c3_out_valid), .out_ready(c3_out_ready),
    .out_data(c3_out_data), .out_chan(c3_out_chan)
  );

  // ---------------- driver tasks ----------------
  task automatic set_default_data;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + i;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    mode = 1'b0; in_valid = '0; out_ready = 1'b0;
    c3_mode = 1'b0; c3_in_valid = '0; c3_out_ready = 1'b0;
    set_default_data();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    set_default_data();
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%h c=%0d r=%b expected v=0 d=0 c=0 r=0000",
               out_valid, out_data, out_chan, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++; $display("FAIL reset_first_ready: got %b expected 0001", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 32'hA0) begin
      failures++;
      $display("FAIL reset_first_grant: got v=%b c=%0d d=%h expected v=1 c=0 d=a0",
               out_valid, out_chan, out_data);
    end
    // Reset while a word is held under backpressure discards it.
    @(negedge clk);
    out_ready = 1'b0; reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_mid_ready: got %b expected 0000", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_state: got v=%b d=%h c=%0d expected v=0 d=0 c=0",
               out_valid, out_data, out_chan);
    end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_chan !== 2'd0 || out_data !== 32'hA0) begin
      failures++; $display("FAIL reset_mid_regrant: got c=%0d d=%h expected c=0 d=a0", out_chan, out_data);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_chan [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    @(negedge clk);
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (in_ready !== (4'b0001 << exp_chan[k])) begin
        failures++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, in_ready, 4'b0001 << exp_chan[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_chan !== exp_chan[k] || out_data !== 32'hA0 + 32'(exp_chan[k])) begin
        failures++;
        $display("FAIL rr_out[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 k, out_valid, out_chan, out_data, exp_chan[k], 32'hA0 + 32'(exp_chan[k]));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fixed_priority;
    do_reset();
    // One round-robin grant to channel 1 moves ptr to 2.
    @(negedge clk);
    mode = 1'b0; in_valid = 4'b0010; out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_chan !== 2'd1) begin
      failures++; $display("FAIL fixed_setup: got c=%0d expected 1", out_chan);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mode = 1'b1; in_valid = 4'b1010;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        failures++; $display("FAIL fixed_ready[%0d]: got %b expected 0010", k, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_chan !== 2'd1 || out_data !== 32'hA1) begin
        failures++; $display("FAIL fixed_out[%0d]: got c=%0d d=%h expected c=1 d=a1", k, out_chan, out_data);
      end
    end
    // Back to round-robin: ptr stayed at 2, so channel 3 wins.
    @(negedge clk);
    mode = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++; $display("FAIL fixed_to_rr_ready: got %b expected 1000", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_chan !== 2'd3 || out_data !== 32'hA3) begin
      failures++; $display("FAIL fixed_to_rr_out: got c=%0d d=%h expected c=3 d=a3", out_chan, out_data);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    @(negedge clk);
    in_data[31:0] = 32'hDEADBEEF; in_valid = 4'b0001; out_ready = 1'b0; mode = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bp_load: got v=%b d=%h expected v=1 d=deadbeef", out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_chan !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d expected v=1 d=deadbeef c=0",
                 k, out_valid, out_data, out_chan);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++; $display("FAIL bp_release_ready: got %b expected 0100", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 32'hA2) begin
      failures++;
      $display("FAIL bp_release_out: got v=%b c=%0d d=%h expected v=1 c=2 d=a2", out_valid, out_chan, out_data);
    end
    @(negedge clk);
    in_valid = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hA2 || out_chan !== 2'd2) begin
      failures++;
      $display("FAIL bp_drain: got v=%b d=%h c=%0d expected v=0 d=a2 c=2", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_wrap3;
    logic [2:0] req      [5] = '{3'b100, 3'b100, 3'b101, 3'b101, 3'b101};
    logic [1:0] exp_chan [5] = '{2'd2,   2'd2,   2'd0,   2'd2,   2'd0};
    do_reset();
    for (int i = 0; i < 3; i++) c3_in_data[i*8 +: 8] = 8'h10 + 8'(i);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      c3_mode = 1'b0; c3_out_ready = 1'b1; c3_in_valid = req[k];
      #1;
      checks++;
      if (c3_in_ready !== (3'b001 << exp_chan[k])) begin
        failures++; $display("FAIL wrap_ready[%0d]: got %b expected %b", k, c3_in_ready, 3'b001 << exp_chan[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (c3_out_valid !== 1'b1 || c3_out_chan !== exp_chan[k] || c3_out_data !== 8'h10 + 8'(exp_chan[k])) begin
        failures++;
        $display("FAIL wrap_out[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d d=%h",
                 k, c3_out_valid, c3_out_chan, c3_out_data, exp_chan[k], 8'h10 + 8'(exp_chan[k]));
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  m_ptr;
    logic        m_ov;
    logic [31:0] m_od;
    logic [1:0]  m_oc;
    logic [3:0]  exp_rdy;
    int          w;
    bit          ld;
    do_reset();
    m_ptr = 2'd0; m_ov = 1'b0; m_od = 32'h0; m_oc = 2'd0;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      in_valid  = 4'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
      w = -1;
      if (mode) begin
        for (int c = 3; c >= 0; c--) if (in_valid[c]) w = c;
      end else begin
        for (int k = 3; k >= 0; k--) if (in_valid[(int'(m_ptr) + k) % 4]) w = (int'(m_ptr) + k) % 4;
      end
      ld = (w >= 0) && (!m_ov || out_ready);
      exp_rdy = ld ? (4'b0001 << w) : 4'b0000;
      #1;
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_ready[%0d]: got %b expected %b", it, in_ready, exp_rdy);
      end
      if (ld) begin
        m_od = in_data[w*32 +: 32];
        m_oc = 2'(w);
        m_ov = 1'b1;
        if (!mode) m_ptr = 2'((w + 1) % 4);
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== m_ov || out_data !== m_od || out_chan !== m_oc) begin
        failures++;
        $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d expected v=%b d=%h c=%0d",
                 it, out_valid, out_data, out_chan, m_ov, m_od, m_oc);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    c3_mode = 1'b0; c3_in_valid = '0; c3_in_data = '0; c3_out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_wrap3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
